// File: rtl/manchester_pkg.sv
// manchester_pkg: state encodings and preamble pattern shared by the Manchester encoder and decoder.
package manchester_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      PREAMBLE = 2'b01,
      SHIFT    = 2'b10
   } state_t;
   localparam logic [7:0] PREAMBLE_PATTERN = 8'h55;
endpackage

// File: rtl/manchester_half_bit_timer.sv
// manchester_half_bit_timer: half-bit tick generator; half_sel is 0 for the first half of a bit, 1 for the second.
module manchester_half_bit_timer #(
   parameter int HALF_BIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic half_tick,
   output logic half_sel
);
   localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
   logic [CW-1:0] cnt;
   assign half_tick = run && (cnt == CW'(HALF_BIT_CYCLES - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt      <= '0;
         half_sel <= 1'b0;
      end else if (!run) begin
         cnt      <= '0;
         half_sel <= 1'b0;
      end else if (half_tick) begin
         cnt      <= '0;
         half_sel <= ~half_sel;
      end else begin
         cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/manchester_encoder.sv
// manchester_encoder: byte-wide valid/ready to IEEE 802.3 Manchester serial line, MSB first.
// Define MANCH_PREAMBLE_EN to prefix each burst with PREAMBLE_BYTES copies of 8'h55.
module manchester_encoder import manchester_pkg::*; #(
   parameter int   HALF_BIT_CYCLES = 4,
   parameter logic IDLE_LEVEL      = 1'b0,
   parameter int   PREAMBLE_BYTES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_valid_in,
   output logic       data_ready,
   output logic       manchester_out,
   output logic       tx_en,
   output logic       busy
);
   if (HALF_BIT_CYCLES < 1 || PREAMBLE_BYTES < 0) begin : g_bad_cfg
      $error("manchester_encoder: illegal HALF_BIT_CYCLES or PREAMBLE_BYTES");
   end
   state_t     state;
   logic [7:0] sr;
   logic [2:0] bit_idx;
   logic       armed;
   logic       half_tick;
   logic       half_sel;
   logic       transfer;
   logic       byte_end;
   logic [7:0] cur_pat;
   logic       cur_bit;
   logic       next_bit;
   manchester_half_bit_timer #(.HALF_BIT_CYCLES(HALF_BIT_CYCLES)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (state != IDLE),
      .half_tick (half_tick),
      .half_sel  (half_sel)
   );
`ifdef MANCH_PREAMBLE_EN
   logic [7:0] pre_cnt;
   logic       pre_last;
   assign pre_last = pre_cnt == 8'(PREAMBLE_BYTES - 1);
   assign cur_pat  = (state == PREAMBLE) ? PREAMBLE_PATTERN : sr;
`else
   assign cur_pat  = sr;
`endif
   assign cur_bit    = cur_pat[bit_idx];
   assign next_bit   = cur_pat[bit_idx - 3'd1];
   assign byte_end   = half_tick && half_sel && bit_idx == 3'd0;
   // armed keeps ready low on the first cycle after reset release
   assign data_ready = (state == IDLE && armed) || (state == SHIFT && byte_end);
   assign transfer   = data_valid_in && data_ready;
   assign tx_en      = busy;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state          <= IDLE;
         sr             <= '0;
         bit_idx        <= '0;
         armed          <= 1'b0;
         busy           <= 1'b0;
         manchester_out <= IDLE_LEVEL;
`ifdef MANCH_PREAMBLE_EN
         pre_cnt        <= '0;
`endif
      end else begin
         armed <= 1'b1;
         if (transfer) begin
            sr      <= data_in;
            bit_idx <= 3'd7;
            busy    <= 1'b1;
`ifdef MANCH_PREAMBLE_EN
            if (state == IDLE && PREAMBLE_BYTES > 0) begin
               state          <= PREAMBLE;
               pre_cnt        <= '0;
               manchester_out <= ~PREAMBLE_PATTERN[7];
            end else begin
               state          <= SHIFT;
               manchester_out <= ~data_in[7];
            end
`else
            state          <= SHIFT;
            manchester_out <= ~data_in[7];
`endif
         end else if (byte_end) begin
`ifdef MANCH_PREAMBLE_EN
            if (state == PREAMBLE) begin
               bit_idx <= 3'd7;
               if (pre_last) begin
                  state          <= SHIFT;
                  manchester_out <= ~sr[7];
               end else begin
                  pre_cnt        <= pre_cnt + 8'd1;
                  manchester_out <= ~PREAMBLE_PATTERN[7];
               end
            end else begin
               state          <= IDLE;
               busy           <= 1'b0;
               manchester_out <= IDLE_LEVEL;
            end
`else
            state          <= IDLE;
            busy           <= 1'b0;
            manchester_out <= IDLE_LEVEL;
`endif
         end else if (half_tick) begin
            if (half_sel) begin
               bit_idx        <= bit_idx - 3'd1;
               manchester_out <= ~next_bit;
            end else begin
               manchester_out <= cur_bit;
            end
         end
      end
endmodule

// File: tb/tb_manchester_encoder.sv
// tb_manchester_encoder: randomized checks of two encoders (HALF_BIT_CYCLES 4 and 1) against a per-cycle line-level model.
module tb_manchester_encoder;
   typedef bit lv_t[$];
`ifdef MANCH_PREAMBLE_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] d0 = '0, d1 = '0;
   logic       v0 = 1'b0, v1 = 1'b0;
   logic       rdy0, rdy1, mo0, mo1, te0, te1, bz0, bz1;
   int         nvec = 0;
   int         nerr = 0;
   lv_t        q0, q1;
   bit         fr = 1'b1;
   bit         idle0, idle1;
   logic [7:0] tx0[$], tx1[$];
   always #5 clk = ~clk;
   manchester_encoder #(.HALF_BIT_CYCLES(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .data_in(d0), .data_valid_in(v0),
      .data_ready(rdy0), .manchester_out(mo0), .tx_en(te0), .busy(bz0)
   );
   manchester_encoder #(.HALF_BIT_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .data_in(d1), .data_valid_in(v1),
      .data_ready(rdy1), .manchester_out(mo1), .tx_en(te1), .busy(bz1)
   );
   // Line levels, one entry per clock, for a byte accepted from idle (start) or back-to-back.
   function automatic lv_t sym(int h, logic [7:0] b, bit start);
      lv_t r;
      logic [7:0] seq[$];
      if (start && PRE) begin
         seq.push_back(8'h55);
         seq.push_back(8'h55);
      end
      seq.push_back(b);
      foreach (seq[j])
         for (int i = 7; i >= 0; i--) begin
            repeat (h) r.push_back(!seq[j][i]);
            repeat (h) r.push_back(seq[j][i]);
         end
      return r;
   endfunction
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         q0.delete();
         q1.delete();
         fr = 1'b1;
      end else begin
         idle0 = q0.size() == 0;
         idle1 = q1.size() == 0;
         if (!idle0) void'(q0.pop_front());
         if (!idle1) void'(q1.pop_front());
         if (v0 && rdy0) q0 = {q0, sym(4, d0, idle0)};
         if (v1 && rdy1) q1 = {q1, sym(1, d1, idle1)};
         fr = 1'b0;
      end
   function automatic logic [3:0] exp0();
      return q0.size() == 0 ? {1'b0, 1'b0, 1'b0, !fr} : {q0[0], 1'b1, 1'b1, q0.size() == 1};
   endfunction
   function automatic logic [3:0] exp1();
      return q1.size() == 0 ? {1'b0, 1'b0, 1'b0, !fr} : {q1[0], 1'b1, 1'b1, q1.size() == 1};
   endfunction
   task automatic test_reset();
      #1;
      nvec++;
      if ({mo0, te0, bz0, rdy0, mo1, te1, bz1, rdy1} !== 8'b0) begin
         nerr++;
         $display("FAIL reset_values got %b expected 00000000", {mo0, te0, bz0, rdy0, mo1, te1, bz1, rdy1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      nvec++;
      if ({rdy0, rdy1} !== 2'b00) begin
         nerr++;
         $display("FAIL ready_first_cycle got %b%b expected 00", rdy0, rdy1);
      end
      @(negedge clk);
      nvec++;
      if ({rdy0, rdy1, bz0, bz1} !== 4'b1100) begin
         nerr++;
         $display("FAIL ready_idle got rdy=%b%b busy=%b%b expected rdy=11 busy=00", rdy0, rdy1, bz0, bz1);
      end
   endtask
   task automatic stream0(input string nm, input int gap, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         nvec++;
         if ({mo0, bz0, te0, rdy0} !== exp0()) begin
            nerr++;
            $display("FAIL %s cycle %0d out/busy/tx_en/ready got %b expected %b", nm, c, {mo0, bz0, te0, rdy0}, exp0());
         end
         if (tx0.size() != 0 && int'($urandom_range(99)) >= gap) begin
            v0 = 1'b1;
            d0 = tx0[0];
            if (rdy0) void'(tx0.pop_front());
         end else begin
            v0 = rdy0 ? 1'b0 : 1'($urandom_range(1));
            d0 = 8'($urandom);
         end
      end
   endtask
   task automatic test_single_byte();
      tx0 = '{8'hA5};
      stream0("single_a5", 0, 70 + 128 * PRE);
   endtask
   task automatic test_back_to_back();
      tx0 = '{8'h00, 8'hFF};
      stream0("b2b_00_ff", 0, 135 + 128 * PRE);
   endtask
   task automatic test_random_gaps();
      tx0.delete();
      repeat (10) tx0.push_back(8'($urandom));
      stream0("random_gaps", 30, 1200);
   endtask
   task automatic test_half_one();
      tx1 = '{8'h3C};
      repeat (5) tx1.push_back(8'($urandom));
      for (int c = 0; c < 130 + 32 * PRE; c++) begin
         @(negedge clk);
         nvec++;
         if ({mo1, bz1, te1, rdy1} !== exp1()) begin
            nerr++;
            $display("FAIL half_one cycle %0d out/busy/tx_en/ready got %b expected %b", c, {mo1, bz1, te1, rdy1}, exp1());
         end
         if (tx1.size() != 0) begin
            v1 = 1'b1;
            d1 = tx1[0];
            if (rdy1) void'(tx1.pop_front());
         end else begin
            v1 = rdy1 ? 1'b0 : 1'($urandom_range(1));
            d1 = 8'($urandom);
         end
      end
   endtask
   task automatic test_reset_mid();
      tx0 = '{8'($urandom)};
      stream0("pre_reset", 0, 21 + 128 * PRE);
      #2 rst_n = 1'b0;
      #1;
      nvec++;
      if ({mo0, te0, bz0, rdy0} !== 4'b0000) begin
         nerr++;
         $display("FAIL reset_mid got out/tx_en/busy/ready %b expected 0000", {mo0, te0, bz0, rdy0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      tx0 = '{8'h81};
      stream0("after_reset_81", 0, 75 + 128 * PRE);
   endtask
   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_random_gaps();
      test_half_one();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
